// File: rtl/seq_counter_ctrl.sv
// rtl/seq_counter_ctrl.sv - round-robin run controller for the 3-bit sequence counter
// Defining SEQ_CHECK_EN adds a run-time checker of the counter sequence driving seq_err.
module seq_counter_ctrl #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req0,
   input  logic             req1,
   input  logic [2:0]       start0,
   input  logic [2:0]       start1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic             abort,
   input  logic [2:0]       cnt_q,
   output logic             cnt_load_en,
   output logic [2:0]       cnt_data,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [2:0]       result,
   output logic             result_abort,
   output logic             busy,
   output logic             seq_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [2:0]       start_q, start_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             abort_q, abort_d;
   logic [2:0]       park_q, park_d;
   logic [2:0]       result_q, result_d;
   logic             result_abort_q, result_abort_d;
   logic             win;

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      owner_d        = owner_q;
      start_d        = start_q;
      rem_d          = rem_q;
      abort_d        = abort_q;
      park_d         = park_q;
      result_d       = result_q;
      result_abort_d = result_abort_q;
      win            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // win=1 selects requester 1; pointer only matters under contention
               win     = (req0 && req1) ? ptr_q : req1;
               owner_d = win;
               ptr_d   = ~win;
               start_d = win ? start1 : start0;
               rem_d   = win ? len1 : len0;
               abort_d = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = (rem_q == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            rem_d = rem_q - LEN_W'(1);
            if (abort) begin
               abort_d = 1'b1;
            end
            if (abort || rem_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end
         end
         default: begin
            result_d       = cnt_q;
            park_d         = cnt_q;
            result_abort_d = abort_q;
            state_d        = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q        <= S_IDLE;
         ptr_q          <= 1'b0;
         owner_q        <= 1'b0;
         start_q        <= 3'b000;
         rem_q          <= '0;
         abort_q        <= 1'b0;
         park_q         <= 3'b000;
         result_q       <= 3'b000;
         result_abort_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         owner_q        <= owner_d;
         start_q        <= start_d;
         rem_q          <= rem_d;
         abort_q        <= abort_d;
         park_q         <= park_d;
         result_q       <= result_d;
         result_abort_q <= result_abort_d;
      end
   end

   always_comb begin
      cnt_load_en = (state_q != S_RUN);
      case (state_q)
         S_LOAD:  cnt_data = start_q;
         S_DONE:  cnt_data = cnt_q;
         default: cnt_data = park_q;
      endcase
   end

   assign gnt0         = (state_q == S_LOAD) && !owner_q;
   assign gnt1         = (state_q == S_LOAD) &&  owner_q;
   assign done0        = (state_q == S_DONE) && !owner_q;
   assign done1        = (state_q == S_DONE) &&  owner_q;
   assign busy         = (state_q != S_IDLE);
   assign result       = result_q;
   assign result_abort = result_abort_q;

`ifdef SEQ_CHECK_EN
   function automatic logic [2:0] seq_next(input logic [2:0] q);
      case (q)
         3'b000:  seq_next = 3'b110;
         3'b001:  seq_next = 3'b110;
         3'b010:  seq_next = 3'b111;
         3'b011:  seq_next = 3'b000;
         3'b100:  seq_next = 3'b111;
         3'b101:  seq_next = 3'b010;
         3'b110:  seq_next = 3'b100;
         default: seq_next = 3'b011;
      endcase
   endfunction

   logic [2:0] exp_q, exp_d;
   logic       err_q, err_d;

   always_comb begin
      exp_d = exp_q;
      err_d = err_q;
      if (state_q == S_LOAD) begin
         exp_d = start_q;
      end else if (state_q == S_RUN) begin
         if (cnt_q != exp_q) begin
            err_d = 1'b1;
         end
         exp_d = seq_next(exp_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         exp_q <= 3'b000;
         err_q <= 1'b0;
      end else begin
         exp_q <= exp_d;
         err_q <= err_d;
      end
   end

   assign seq_err = err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule
